pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [6:0] NOP_OPCODE = 7'b0010011;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand bypass selector for one EX source register; MEM wins over WB.
module fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] rs,
  input  logic          mem_wen,
  input  logic [RW-1:0] mem_rd,
  input  logic          wb_wen,
  input  logic [RW-1:0] wb_rd,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_wen && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wen && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: forwarding select, load-use bubbles, mispredict
// flush and a halt drain FSM. dbg_state / dbg_lu_cnt expose internal state.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int RW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int DRAIN    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic          id_halt,
  input  logic          ex_valid,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_load,
  input  logic [RW-1:0] ex_rs1,
  input  logic [RW-1:0] ex_rs2,
  input  logic          ex_mispredict,
  input  logic [RW-1:0] mem_rd,
  input  logic [RW-1:0] wb_rd,
  input  logic          mem_wen,
  input  logic          wb_wen,
  output logic          stall_if,
  output logic          stall_id,
  output logic          flush_ifid,
  output logic          flush_idex,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          draining,
  output logic          halted,
  output logic [1:0]    dbg_state,
  output logic [1:0]    dbg_lu_cnt
);

  hz_state_e  state_q;
  logic [1:0] lu_cnt_q;
  logic [2:0] drain_cnt_q;
  logic       lu_hazard;
  logic       lu_stall;
  logic       unused_params;

  // XLEN and the NOP encoding document the surrounding datapath only.
  assign unused_params = (XLEN > 0) && (NOP_OPCODE != 7'd0);

  fwd_sel #(.RW(RW)) u_fwd_a (
    .rs(ex_rs1), .mem_wen(mem_wen), .mem_rd(mem_rd),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .sel(fwd_a)
  );

  fwd_sel #(.RW(RW)) u_fwd_b (
    .rs(ex_rs2), .mem_wen(mem_wen), .mem_rd(mem_rd),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .sel(fwd_b)
  );

  assign lu_hazard = ex_valid && ex_load && (ex_rd != '0) && id_valid &&
                     ((id_use1 && (id_rs1 == ex_rd)) ||
                      (id_use2 && (id_rs2 == ex_rd)));
  assign lu_stall  = lu_hazard || (lu_cnt_q != 2'd0);

  assign draining = (state_q == ST_DRAIN);
  assign halted   = (state_q == ST_HALTED);

  // A mispredict kills the wrong-path work, so it releases any stall; a
  // halted pipe stays frozen regardless.
  assign stall_if   = halted || (!ex_mispredict && (lu_stall || draining));
  assign stall_id   = halted || (!ex_mispredict && lu_stall);
  assign flush_ifid = ex_mispredict || draining;
  assign flush_idex = ex_mispredict || lu_stall || halted;

  assign dbg_state  = state_q;
  assign dbg_lu_cnt = lu_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      lu_cnt_q    <= 2'd0;
      drain_cnt_q <= 3'd0;
    end else begin
      if (ex_mispredict) begin
        lu_cnt_q <= 2'd0;
      end else if (lu_hazard) begin
        lu_cnt_q <= 2'(LOAD_LAT - 1);
      end else if (lu_cnt_q != 2'd0) begin
        lu_cnt_q <= lu_cnt_q - 2'd1;
      end

      case (state_q)
        ST_RUN: begin
          if (id_valid && id_halt && !lu_stall && !ex_mispredict) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= 3'(DRAIN - 1);
          end
        end
        ST_DRAIN: begin
          if (ex_mispredict) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 3'd0;
          end else if (drain_cnt_q == 3'd0) begin
            state_q <= ST_HALTED;
          end else begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

endmodule
